// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: ALUOp classes, register-index width,
// hazard FSM state type and the ID/EX bubble control word.
package riscv_pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       valid;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: compares the load sitting in ID/EX against the
// source registers of the instruction currently in decode. Purely combinational.
module hazard_detection_unit
    import riscv_pipe_pkg::*;
(
    input  logic                 ID_EXE_MemRead,
    input  logic                 ID_EXE_valid,
    input  logic [REG_IDX_W-1:0] ID_EXE_rd,
    input  logic                 IF_ID_valid,
    input  logic [REG_IDX_W-1:0] IF_ID_rs1,
    input  logic [REG_IDX_W-1:0] IF_ID_rs2,
    input  logic                 ID_uses_rs2,
    output logic                 load_use
);

    // x0 is never a real producer, so it can never create a dependency
    always_comb begin
        load_use = ID_EXE_MemRead & ID_EXE_valid & (ID_EXE_rd != '0) & IF_ID_valid &
                   ((ID_EXE_rd == IF_ID_rs1) | (ID_uses_rs2 & (ID_EXE_rd == IF_ID_rs2)));
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with load-use stall FSM.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles performance counter.
module id_exe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] IF_ID_rs1,
    input  logic [REG_IDX_W-1:0] IF_ID_rs2,
    input  logic [REG_IDX_W-1:0] IF_ID_rd,
    input  logic                 IF_ID_valid,
    input  logic                 ID_uses_rs2,
    input  logic                 ID_RegWrite,
    input  logic                 ID_MemRead,
    input  logic                 ID_MemWrite,
    input  logic                 ID_MemToReg,
    input  logic                 ID_ALUSrc,
    input  logic [1:0]           ID_ALUOp,
    input  logic [XLEN-1:0]      ID_rs1_data,
    input  logic [XLEN-1:0]      ID_rs2_data,
    input  logic [XLEN-1:0]      ID_imm,
    input  logic                 EX_flush,
    output logic [REG_IDX_W-1:0] ID_EXE_rs1,
    output logic [REG_IDX_W-1:0] ID_EXE_rs2,
    output logic [REG_IDX_W-1:0] ID_EXE_rd,
    output logic                 ID_EXE_RegWrite,
    output logic                 ID_EXE_MemRead,
    output logic                 ID_EXE_MemWrite,
    output logic                 ID_EXE_MemToReg,
    output logic                 ID_EXE_ALUSrc,
    output logic [1:0]           ID_EXE_ALUOp,
    output logic                 ID_EXE_valid,
    output logic [XLEN-1:0]      ID_EXE_rs1_data,
    output logic [XLEN-1:0]      ID_EXE_rs2_data,
    output logic [XLEN-1:0]      ID_EXE_imm,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 PC_write,
    output logic                 IF_ID_write
);

    hz_state_t state, state_next;
    ctrl_t     ctrl_q, ctrl_d;
    logic      load_use;
    logic      stall_req;
    logic      bubble;

    hazard_detection_unit u_hdu (
        .ID_EXE_MemRead (ctrl_q.mem_read),
        .ID_EXE_valid   (ctrl_q.valid),
        .ID_EXE_rd      (ID_EXE_rd),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .ID_uses_rs2    (ID_uses_rs2),
        .load_use       (load_use)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // FSM next state: a flush overrides the stall, and a stall lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (load_use && !EX_flush) state_next = STALL;
            STALL:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM outputs: fetch/decode hold is combinational from the hazard
    always_comb begin
        stall_req   = load_use & ~EX_flush;
        PC_write    = ~stall_req;
        IF_ID_write = ~stall_req;
    end

    // Bubble selection and decode control packing
    always_comb begin
        bubble = EX_flush | load_use | ~IF_ID_valid;
        ctrl_d = '{reg_write:  ID_RegWrite,
                   mem_read:   ID_MemRead,
                   mem_write:  ID_MemWrite,
                   mem_to_reg: ID_MemToReg,
                   alu_src:    ID_ALUSrc,
                   alu_op:     ID_ALUOp,
                   valid:      1'b1};
    end

    // ID/EX pipeline register; a bubble zeroes every field so forwarding never matches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q          <= BUBBLE_CTRL;
            ID_EXE_rs1      <= '0;
            ID_EXE_rs2      <= '0;
            ID_EXE_rd       <= '0;
            ID_EXE_rs1_data <= '0;
            ID_EXE_rs2_data <= '0;
            ID_EXE_imm      <= '0;
        end else if (bubble) begin
            ctrl_q          <= BUBBLE_CTRL;
            ID_EXE_rs1      <= '0;
            ID_EXE_rs2      <= '0;
            ID_EXE_rd       <= '0;
            ID_EXE_rs1_data <= '0;
            ID_EXE_rs2_data <= '0;
            ID_EXE_imm      <= '0;
        end else begin
            ctrl_q          <= ctrl_d;
            ID_EXE_rs1      <= IF_ID_rs1;
            ID_EXE_rs2      <= IF_ID_rs2;
            ID_EXE_rd       <= IF_ID_rd;
            ID_EXE_rs1_data <= ID_rs1_data;
            ID_EXE_rs2_data <= ID_rs2_data;
            ID_EXE_imm      <= ID_imm;
        end
    end

    assign ID_EXE_RegWrite = ctrl_q.reg_write;
    assign ID_EXE_MemRead  = ctrl_q.mem_read;
    assign ID_EXE_MemWrite = ctrl_q.mem_write;
    assign ID_EXE_MemToReg = ctrl_q.mem_to_reg;
    assign ID_EXE_ALUSrc   = ctrl_q.alu_src;
    assign ID_EXE_ALUOp    = ctrl_q.alu_op;
    assign ID_EXE_valid    = ctrl_q.valid;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles spent in STALL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              stall_cnt <= '0;
        else if (state == STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 Parameter XLEN, default 64, register-data and immediate width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 IF_ID_rs1, IF_ID_rs2, IF_ID_rd  input  5 each  register fields of instruction in decode.
REQ-005 IF_ID_valid  input  1  decode slot holds a real instruction.
REQ-006 ID_uses_rs2  input  1  decoded instruction reads rs2 (R/S/B-type).
REQ-007 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc  input  1 each  decoded controls.
REQ-008 ID_ALUOp  input  2  decoded ALU operation class.
REQ-009 ID_rs1_data, ID_rs2_data, ID_imm  input  XLEN each  register-file reads and immediate.
REQ-010 EX_flush  input  1  taken branch/jump resolved in EX; squash decode slot.
REQ-011 ID_EXE_rs1, ID_EXE_rs2, ID_EXE_rd  output  5 each  registered fields, consumed by forwarding unit.
REQ-012 ID_EXE_RegWrite, ID_EXE_MemRead, ID_EXE_MemWrite, ID_EXE_MemToReg, ID_EXE_ALUSrc, ID_EXE_ALUOp, ID_EXE_valid  output  1/1/1/1/1/2/1  registered controls.
REQ-013 ID_EXE_rs1_data, ID_EXE_rs2_data, ID_EXE_imm  output  XLEN each  registered operands.
REQ-014 PC_write, IF_ID_write  output  1 each  fetch/decode enables; 0 = hold.
REQ-015 stall_cycles  output  32  load-use stall count (only with REQ-027 macro).

Function
REQ-016 load_use SHALL be ID_EXE_MemRead & ID_EXE_valid & (ID_EXE_rd != 0) & IF_ID_valid & ((ID_EXE_rd == IF_ID_rs1) | (ID_uses_rs2 & ID_EXE_rd == IF_ID_rs2)), combinational from registered state.
REQ-017 FSM states RUN, STALL: RUN->STALL on load_use & !EX_flush; STALL->RUN unconditionally next cycle; stall never exceeds one cycle per load.
REQ-018 PC_write = IF_ID_write = !(load_use & !EX_flush), same cycle, no register delay.
REQ-019 Each rising edge: if EX_flush or load_use or !IF_ID_valid, capture bubble; else capture all decode inputs; latency 1 cycle.
REQ-020 Bubble SHALL be all controls 0, valid 0, rs1/rs2/rd 0, data fields 0 (so forwarding unit never matches a bubble).
REQ-021 EX_flush SHALL take priority over load_use: bubble inserted, PC_write/IF_ID_write stay 1, FSM stays RUN.
REQ-022 Back-to-back loads: second load with no dependency on first SHALL pass without stall; dependent consumer after second load SHALL stall exactly once.
REQ-023 rd = x0 destination SHALL never cause a stall.

Reset
REQ-024 While rst_n = 0 every registered output SHALL be 0, FSM = RUN, stall_cycles = 0; PC_write = IF_ID_write = 1.
REQ-025 Reset asserted mid-stall SHALL clear stall immediately (asynchronous), no pending bubble after release.
REQ-026 First edge after rst_n release SHALL capture normally.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN: defined -> stall_cycles increments by 1 on each edge where state = STALL, saturates at 0xFFFF_FFFF; undefined -> port absent, no counter logic.

Structure
REQ-028 Shared package riscv_pipe_pkg holds ALUOp encodings, register-index width (5), FSM state typedef, bubble control constant.
REQ-029 Hazard detection (REQ-016) SHALL be sub-module hazard_detection_unit, combinational; pipeline register and FSM remain in id_exe_stage.

Verification
REQ-030 ld x2,0(x1) then add x3,x2,x4: cycle after ld enters EX -> PC_write=0, IF_ID_write=0 one cycle, bubble (valid=0, rd=0) in ID/EX, then add captured with rs1=2.
REQ-031 ld x0,0(x1) then add x3,x0,x4 -> no stall, PC_write stays 1.
REQ-032 ld x2 then sd x2,100(x5) with ID_uses_rs2=1 -> one-cycle stall; same with ID_uses_rs2=0 and rs1=5 -> no stall.
REQ-033 load_use and EX_flush same cycle -> bubble, PC_write=1, FSM RUN, no stall next cycle.
REQ-034 rst_n pulled low during STALL -> outputs 0, PC_write=1 immediately; with HAZARD_PERF_CNT_EN, three separate load-use stalls -> stall_cycles = 3.
